// File: rtl/i2c_target_pkg.sv
// Shared I2C definitions for the target and the controller side.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_target_pkg;

    // Target protocol states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_t;

    // R/W bit values as they appear in the address byte LSB
    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

    // Address of the sound/DAC target on the alarm bus
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h4C;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one bus line with rise/fall detection.
// Latency: q follows d after 2 clk; rise/fall valid for the one cycle after q changes.
// Backpressure: none; free-running sampler.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronize the pin and keep the previous synced value; reset to the idle (high) bus level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target: ACKs ADDR, delivers written bytes on rx_data/rx_valid, returns tx_data on reads.
// Latency: bus edges act 3 CLK after the pin; rx_valid 1 CLK after the 8th data scl_rise is seen.
// Backpressure: none; SCL is never stretched, tx_data must be ready by the scl_fall after tx_req.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR = I2C_DEFAULT_ADDR
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    inout  wire        Data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic scl_q, scl_rise, scl_fall;
    logic sda_q, sda_rise, sda_fall;
    logic start_c, stop_c, bus_cond;

    i2c_state_t state, state_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [7:0] shreg, shreg_d, rx_data_d;
    logic       oe, oe_d;
    logic       ack_seen, ack_seen_d;
    logic       rx_valid_d, tx_req_d, busy_d;
    logic       last_bit, enter_rd;

    i2c_sync_edge u_scl (
        .clk   (CLK),
        .rst_n (RST),
        .d     (SCL),
        .q     (scl_q),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk   (CLK),
        .rst_n (RST),
        .d     (Data),
        .q     (sda_q),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // SDA moving while SCL is high is a bus condition and beats any SCL edge in the same cycle
    assign start_c  = sda_fall & scl_q;
    assign stop_c   = sda_rise & scl_q;
    assign bus_cond = start_c | stop_c;
    assign last_bit = (bit_cnt == 3'd7);

    // Open drain: only ever pull low or let go
    assign Data = oe ? 1'b0 : 1'bz;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            oe       <= 1'b0;
            ack_seen <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            oe       <= oe_d;
            ack_seen <= ack_seen_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            tx_req   <= tx_req_d;
            busy     <= busy_d;
        end
    end

    // Next-state: START/STOP first, then the per-state SCL edge handling
    always_comb begin
        state_d = state;
        if (start_c) begin
            state_d = ST_ADDR;
        end else if (stop_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR: begin
                    // shreg[6:0] holds the 7 address bits when the R/W bit arrives
                    if (scl_rise && last_bit)
                        state_d = (shreg[6:0] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                end
                ST_ADDR_ACK: begin
                    // oe high means the ACK slot is in progress; this fall ends it
                    if (scl_fall && oe)
                        state_d = (shreg[0] == I2C_RD) ? ST_RD_BYTE : ST_WR_BYTE;
                end
                ST_WR_BYTE: begin
                    if (scl_rise && last_bit) state_d = ST_WR_ACK;
                end
                ST_WR_ACK: begin
                    if (scl_fall && oe) state_d = ST_WR_BYTE;
                end
                ST_RD_BYTE: begin
                    if (scl_fall && last_bit) state_d = ST_RD_ACK;
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_q)        state_d = ST_IGNORE;
                    else if (scl_fall && ack_seen) state_d = ST_RD_BYTE;
                end
                default: ;
            endcase
        end
    end

    // Outputs and datapath next values; oe only changes on scl_fall so SDA never moves while SCL is high
    always_comb begin
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        oe_d       = oe;
        ack_seen_d = 1'b0;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy;
        enter_rd   = (state_d == ST_RD_BYTE) && (state != ST_RD_BYTE);

        if (bus_cond) begin
            // Partial bytes are dropped; busy re-arms only on a fresh address match
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg[6:0], sda_q};
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (state_d == ST_ADDR_ACK) begin
                            busy_d   = 1'b1;
                            tx_req_d = (sda_q == I2C_RD);
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    // First fall starts the ACK pull-down, second fall releases it
                    if (scl_fall) oe_d = ~oe;
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg[6:0], sda_q};
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (last_bit) begin
                            rx_data_d  = {shreg[6:0], sda_q};
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        // Rotate so the MSB position always holds the bit on the bus
                        shreg_d   = {shreg[6:0], shreg[7]};
                        bit_cnt_d = bit_cnt + 3'd1;
                        oe_d      = !last_bit && !shreg[6];
                    end
                end
                ST_RD_ACK: begin
                    tx_req_d   = scl_rise && !sda_q;
                    ack_seen_d = ack_seen || (scl_rise && !sda_q);
                end
                default: oe_d = 1'b0;
            endcase

            if (enter_rd) begin
                shreg_d   = tx_data;
                bit_cnt_d = 3'd0;
                oe_d      = ~tx_data[7];
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller, rx scoreboard, tx_data supplier.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_target;
    import i2c_target_pkg::*;

    localparam int T = 40;   // quarter SCL period

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    int checks = 0;
    int failures = 0;
    int drive_cnt = 0;
    int txreq_cnt = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_src[$];
    logic [7:0] wbuf[4];
    logic [7:0] tbuf[4];

    i2c_target #(.ADDR(I2C_DEFAULT_ADDR)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SCL      (scl),
        .Data     (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: rx scoreboard, tx_data supply on request, count target pull-downs
    always @(negedge CLK) begin
        if (rx_valid) begin
            if (exp_rx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected: got rx_data %0h with nothing expected", rx_data);
            end else begin
                check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
        end
        if (tx_req) begin
            txreq_cnt++;
            tx_data = (tx_src.size() != 0) ? tx_src.pop_front() : 8'hEE;
        end
        if (sda === 1'b0 && !m_low) drive_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One SCL clock with the controller putting b on SDA (1 = release); r = SDA mid-high
    task automatic bit_cycle(input logic b, output logic r);
        m_low = ~b;
        #(T); scl = 1'b1;
        #(T); r = sda;
        #(T); scl = 1'b0;
        #(T);
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        #(T); scl = 1'b1;
        #(T); m_low = 1'b1;
        #(T); scl = 1'b0;
        #(T);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1;
        #(T); scl = 1'b1;
        #(T); m_low = 1'b0;
        #(4 * T);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
        bit_cycle(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] rb);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, r);
            rb[i] = r;
        end
        bit_cycle(nack, r);
    endtask

    // Reference model: a target at the default address ACKs and exchanges every byte; others stay silent
    task automatic xfer(input logic [6:0] a, input logic rw, input int n);
        logic hit, ack;
        logic [7:0] rb;
        int drv0, req0;
        hit  = (a == I2C_DEFAULT_ADDR);
        drv0 = drive_cnt;
        req0 = txreq_cnt;
        if (hit && rw == I2C_RD)
            for (int i = 0; i < n; i++) tx_src.push_back(tbuf[i]);
        i2c_start();
        send_byte({a, rw}, ack);
        check("addr_ack", 32'(ack), 32'(!hit));
        check("busy_in_xfer", 32'(busy), 32'(hit));
        for (int i = 0; i < n; i++) begin
            if (rw == I2C_WR) begin
                if (hit) exp_rx.push_back(wbuf[i]);
                send_byte(wbuf[i], ack);
                check("data_ack", 32'(ack), 32'(!hit));
            end else begin
                recv_byte(i == n - 1, rb);
                check("rd_byte", 32'(rb), hit ? 32'(tbuf[i]) : 32'hFF);
            end
        end
        if (hit && rw == I2C_RD) check("rel_after_nack", 32'(sda), 32'd1);
        i2c_stop();
        check("busy_after_stop", 32'(busy), 32'd0);
        check("rx_pending", 32'(exp_rx.size()), 32'd0);
        check("txreq_cnt", 32'(txreq_cnt - req0), (hit && rw == I2C_RD) ? 32'(n) : 32'd0);
        if (!hit) check("no_drive", 32'(drive_cnt - drv0), 32'd0);
    endtask

    initial begin
        logic ack, r;
        logic [7:0] rb;
        int drv0, req0;

        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        RST = 1'b1;
        @(posedge CLK); #2;

        // Single write
        wbuf[0] = 8'hA5;
        xfer(I2C_DEFAULT_ADDR, I2C_WR, 1);
        check("wr_rx_data", 32'(rx_data), 32'hA5);

        // Foreign address
        wbuf[0] = 8'h33;
        xfer(7'h20, I2C_WR, 1);

        // Read one byte, NACK
        tbuf[0] = 8'h3C;
        xfer(I2C_DEFAULT_ADDR, I2C_RD, 1);

        // Read two bytes with ACK between
        tbuf[0] = 8'h3C;
        tbuf[1] = 8'h81;
        xfer(I2C_DEFAULT_ADDR, I2C_RD, 2);

        // Repeated START after 4 data bits, then a full write
        i2c_start();
        send_byte({I2C_DEFAULT_ADDR, I2C_WR}, ack);
        check("rs_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) bit_cycle(i[0], r);
        wbuf[0] = 8'h5A;
        xfer(I2C_DEFAULT_ADDR, I2C_WR, 1);
        check("rs_rx_data", 32'(rx_data), 32'h5A);

        // Reset while the target is driving read bit 0
        req0 = txreq_cnt;
        tx_src.push_back(8'h3C);
        i2c_start();
        send_byte({I2C_DEFAULT_ADDR, I2C_RD}, ack);
        check("rst_addr_ack", 32'(ack), 32'd0);
        rb = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            bit_cycle(1'b1, r);
            rb[i] = r;
        end
        check("rst_rd_bits", 32'(rb[7:1]), 32'h1E);
        check("rst_bit0_drv", 32'(sda), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_release", 32'(sda), 32'd1);
        check("rst2_rx_data", 32'(rx_data), 32'd0);
        check("rst2_rx_valid", 32'(rx_valid), 32'd0);
        check("rst2_tx_req", 32'(tx_req), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        RST = 1'b1;
        @(posedge CLK); #2;
        drv0 = drive_cnt;
        repeat (3) bit_cycle(1'b1, r);
        check("rst_no_resp", 32'(drive_cnt - drv0), 32'd0);
        i2c_stop();
        check("rst_txreq", 32'(txreq_cnt - req0), 32'd1);
        wbuf[0] = 8'hC3;
        xfer(I2C_DEFAULT_ADDR, I2C_WR, 1);

        // Randomized transfers
        repeat (12) begin
            logic [6:0] a;
            logic       rw;
            int         n;
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : I2C_DEFAULT_ADDR;
            rw = 1'($urandom);
            n  = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) begin
                wbuf[i] = 8'($urandom);
                tbuf[i] = 8'($urandom);
            end
            xfer(a, rw, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
